// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over 2-5 states,
// with memory handshake (mem_req/mem_ready) and PC/IR write enables.
// Ports: clk, reset_n, op, zero, mem_ready in; datapath controls, state out.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_RESET    = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t cur_st;
  state_t nxt_st;
  logic   pc_write;
  logic   branch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_st <= S_RESET;
    end else begin
      cur_st <= nxt_st;
    end
  end

  always_comb begin
    nxt_st     = S_FETCH;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    unique case (cur_st)
      S_RESET: begin
        nxt_st = S_FETCH;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt_st    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (op)
          OP_LW,
          OP_SW:   nxt_st = S_MEMADR;
          OP_R:    nxt_st = S_EXECUTE;
          OP_BEQ:  nxt_st = S_BRANCH;
          OP_ADDI: nxt_st = S_ADDIEXEC;
          OP_J:    nxt_st = S_JUMP;
          default: begin
            nxt_st     = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Only lw/sw reach here; anything else restarts safely.
        if (op == OP_LW) begin
          nxt_st = S_MEMRD;
        end else if (op == OP_SW) begin
          nxt_st = S_MEMWR;
        end else begin
          nxt_st = S_FETCH;
        end
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        nxt_st  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        nxt_st    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt_st    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_st    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: begin
        nxt_st = S_FETCH;
      end
    endcase
  end

  assign pc_en = pc_write | (branch & zero);
  assign state = cur_st;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller.
// Walks each instruction class, memory waits and async reset.
module tb_multicycle_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_op;
  logic [3:0] state;

  int total;
  int bad;

  multicycle_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] outs;
  assign outs = {mem_req, mem_write, iord, ir_write, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b,
                 alu_op, pc_src, pc_en, illegal_op};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    op        = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;

    tick();
    tick();
    chk("rst_state", 32'(state), 32'd15);
    chk("rst_outs", 32'(outs), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("fetch_state", 32'(state), 32'd0);
    chk("fetch_irw", 32'(ir_write), 32'd1);
    chk("fetch_pcen", 32'(pc_en), 32'd1);
    chk("fetch_srcb", 32'(alu_src_b), 32'd1);
    chk("fetch_req", 32'(mem_req), 32'd1);

    // R-type
    op = 6'b000000;
    tick();
    chk("r_s1", 32'(state), 32'd1);
    chk("dec_srcb", 32'(alu_src_b), 32'd3);
    tick();
    chk("r_s6", 32'(state), 32'd6);
    chk("r_aluop", 32'(alu_op), 32'd2);
    chk("r_srca", 32'(alu_src_a), 32'd1);
    tick();
    chk("r_s7", 32'(state), 32'd7);
    chk("r_regw", 32'(reg_write), 32'd1);
    chk("r_regdst", 32'(reg_dst), 32'd1);
    tick();
    chk("r_s0", 32'(state), 32'd0);

    // lw with two wait cycles in MEMRD
    op = 6'b100011;
    tick();
    chk("lw_s1", 32'(state), 32'd1);
    tick();
    chk("lw_s2", 32'(state), 32'd2);
    chk("lw_srcb", 32'(alu_src_b), 32'd2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) mem_ready = 1'b1;
      #1;
      chk($sformatf("lw_s3_%0d", i), 32'(state), 32'd3);
      chk($sformatf("lw_req_%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("lw_iord_%0d", i), 32'(iord), 32'd1);
    end
    tick();
    chk("lw_s4", 32'(state), 32'd4);
    chk("lw_regw", 32'(reg_write), 32'd1);
    chk("lw_m2r", 32'(mem_to_reg), 32'd1);
    tick();
    chk("lw_s0", 32'(state), 32'd0);

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      op   = 6'b000100;
      zero = z[0];
      tick();
      tick();
      chk($sformatf("beq_s8_z%0d", z), 32'(state), 32'd8);
      chk($sformatf("beq_pcen_z%0d", z), 32'(pc_en), 32'(z));
      chk($sformatf("beq_pcsrc_z%0d", z), 32'(pc_src), 32'd1);
      chk($sformatf("beq_aluop_z%0d", z), 32'(alu_op), 32'd1);
      tick();
      chk($sformatf("beq_s0_z%0d", z), 32'(state), 32'd0);
    end
    zero = 1'b0;

    // sw
    op = 6'b101011;
    tick();
    chk("sw_s1", 32'(state), 32'd1);
    chk("sw_dec_mw", 32'(mem_write), 32'd0);
    tick();
    chk("sw_s2", 32'(state), 32'd2);
    chk("sw_adr_mw", 32'(mem_write), 32'd0);
    tick();
    chk("sw_s5", 32'(state), 32'd5);
    chk("sw_mw", 32'(mem_write), 32'd1);
    chk("sw_iord", 32'(iord), 32'd1);
    tick();
    chk("sw_s0", 32'(state), 32'd0);
    chk("sw_f_mw", 32'(mem_write), 32'd0);

    // j
    op = 6'b000010;
    tick();
    tick();
    chk("j_s11", 32'(state), 32'd11);
    chk("j_pcsrc", 32'(pc_src), 32'd2);
    chk("j_pcen", 32'(pc_en), 32'd1);
    tick();
    chk("j_s0", 32'(state), 32'd0);

    // addi
    op = 6'b001000;
    tick();
    tick();
    chk("addi_s9", 32'(state), 32'd9);
    chk("addi_srcb", 32'(alu_src_b), 32'd2);
    tick();
    chk("addi_s10", 32'(state), 32'd10);
    chk("addi_regw", 32'(reg_write), 32'd1);
    chk("addi_regdst", 32'(reg_dst), 32'd0);
    tick();
    chk("addi_s0", 32'(state), 32'd0);

    // illegal opcode
    op = 6'b111111;
    tick();
    chk("ill_s1", 32'(state), 32'd1);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    chk("ill_regw", 32'(reg_write), 32'd0);
    chk("ill_mw", 32'(mem_write), 32'd0);
    tick();
    chk("ill_s0", 32'(state), 32'd0);
    chk("ill_flag_clr", 32'(illegal_op), 32'd0);

    // FETCH wait: no IR/PC update
    mem_ready = 1'b0;
    #1;
    chk("fwait_irw", 32'(ir_write), 32'd0);
    chk("fwait_pcen", 32'(pc_en), 32'd0);
    tick();
    chk("fwait_s0", 32'(state), 32'd0);
    chk("fwait_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;

    // sw waiting in MEMWR, then async reset
    op = 6'b101011;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("swr_s5", 32'(state), 32'd5);
    chk("swr_mw", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd15);
    chk("arst_mw", 32'(mem_write), 32'd0);
    chk("arst_outs", 32'(outs), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("arst_hold", 32'(state), 32'd15);
    reset_n = 1'b1;
    tick();
    chk("arst_fetch", 32'(state), 32'd0);
    chk("arst_irw", 32'(ir_write), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
